// File: rtl/hazard_detection_unit.sv
// Load-use hazard detection, stall control and redirect flush for a 5-stage pipeline.
module hazard_detection_unit #(
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_reg_write_i,
  input  logic                  id_mem_read_i,
  input  logic                  ex_redirect_i,
  output logic                  bubble_o,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  if_id_flush_o,
  output logic [CNT_W-1:0]      stall_count_o
);

  localparam int unsigned STALL_CNT_W = 2;

  typedef enum logic {IDLE, STALL} state_e;

  state_e                  state_q, state_d;
  logic [STALL_CNT_W-1:0]  cnt_q, cnt_d;
  logic                    ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0]   ex_rd_q, ex_rd_d;
  logic                    ex_mem_read_q, ex_mem_read_d;
  logic                    ex_reg_write_q, ex_reg_write_d;
  logic [CNT_W-1:0]        stall_count_q, stall_count_d;
  logic                    luh;
  logic                    stall_active;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    luh = id_valid_i & ex_valid_q & ex_mem_read_q & ex_reg_write_q
          & (ex_rd_q != '0)
          & ((id_uses_rs1_i & (id_rs1_i == ex_rd_q)) |
             (id_uses_rs2_i & (id_rs2_i == ex_rd_q)));
  end

  // Next-state and pipeline control; redirect outranks any stall, reset forces a frozen bubble.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bubble_o      = 1'b0;
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    stall_active  = 1'b0;

    if (ex_redirect_i) begin
      bubble_o      = 1'b1;
      if_id_flush_o = 1'b1;
      state_d       = IDLE;
      cnt_d         = '0;
    end else if (state_q == STALL) begin
      bubble_o      = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      stall_active  = 1'b1;
      cnt_d         = cnt_q - STALL_CNT_W'(1);
      if (cnt_q == STALL_CNT_W'(1)) begin
        state_d = IDLE;
      end
    end else if (luh) begin
      bubble_o      = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      stall_active  = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = STALL;
        cnt_d   = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);
      end
    end

    if (!reset) begin
      bubble_o      = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b0;
    end
  end

  // Shadow of the instruction entering EX; a bubble never produces a load or a register write.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_rd_d        = ex_rd_q;
    ex_mem_read_d  = 1'b0;
    ex_reg_write_d = 1'b0;
    if (!bubble_o) begin
      ex_valid_d     = id_valid_i;
      ex_rd_d        = id_rd_i;
      ex_mem_read_d  = id_mem_read_i;
      ex_reg_write_d = id_reg_write_i;
    end
  end

  // Saturating count of load-use stall cycles.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_active && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // State, shadow and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_reg_write_q <= ex_reg_write_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign stall_count_o = stall_count_q;

endmodule
